// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// MEM-stage data-memory responder. It takes the memory-stage control and data
// from the EX/MEM register and performs one multi-cycle word access against an
// internal synchronous RAM. While the access is in flight it asks the hazard
// unit to hold the pipeline. Load data is returned in a register that feeds
// MEM/WB.
//
// Parameters
//   DEPTH    memory size in 32-bit words (power of two)
//   AW       word-index width, log2(DEPTH)
//   LATENCY  cycles spent in BUSY (1..15)
//
// Ports
//   clk        pipeline clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   MemWriteM  store request
//   MemtoRegM  load request (a store wins if both are high)
//   Alu_outM   byte address; word index is Alu_outM[AW+1:2], upper bits wrap
//   busbM      store data
//   rdataM     registered load data, valid in the DONE cycle and held after it
//   stallM     hold request: (IDLE & req) | BUSY
//   ackM       one-cycle completion pulse (the DONE cycle)
//   errM       one-cycle misalignment pulse
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, a request with Alu_outM[1:0] != 0 goes
//                          straight from IDLE to DONE with ackM = errM = 1,
//                          rdataM = 0 and no memory write. When undefined, the
//                          low address bits are ignored and errM is tied to 0.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] Alu_outM,
    input  logic [31:0] busbM,
    output logic [31:0] rdataM,
    output logic        stallM,
    output logic        ackM,
    output logic        errM
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            op_write;
    logic [AW-1:0]   idx;
    logic [31:0]     data;
    logic [31:0]     rdata;
    logic            ack;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic [AW-1:0]   req_idx;
    logic            misaligned;
    logic            commit;

    assign req     = MemWriteM | MemtoRegM;
    assign req_idx = Alu_outM[AW+1:2];

    // The access is committed on the edge that leaves BUSY.
    assign commit  = (state == ST_BUSY) && (cnt == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err;
    logic unused_addr;

    assign misaligned  = (Alu_outM[1:0] != 2'b00);
    assign unused_addr = ^Alu_outM[31:AW+2];
    assign errM        = err;
`else
    logic unused_addr;

    // Byte offset is ignored: misaligned accesses act on the containing word.
    assign misaligned  = 1'b0;
    assign unused_addr = ^{Alu_outM[31:AW+2], Alu_outM[1:0]};
    assign errM        = 1'b0;
`endif

    // Combinational so the hazard unit sees the hold in the same cycle the
    // request first appears.
    assign stallM = ((state == ST_IDLE) && req) || (state == ST_BUSY);
    assign ackM   = ack;
    assign rdataM = rdata;

    // RAM write port. No reset: contents are neither cleared nor initialised.
    // A reset during BUSY forces state to IDLE, so commit drops and the
    // pending write is discarded.
    always_ff @(posedge clk) begin
        if (commit && op_write) begin
            mem[idx] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            idx      <= '0;
            data     <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
                    err <= 1'b0;
`endif
                    if (req) begin
                        if (misaligned) begin
                            // Trap: skip BUSY entirely, never touch memory.
                            state <= ST_DONE;
                            rdata <= '0;
                            ack   <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                            err   <= 1'b1;
`endif
                        end else begin
                            // Operands come only from these capture registers
                            // from here on; later input changes are ignored.
                            op_write <= MemWriteM;
                            idx      <= req_idx;
                            data     <= busbM;
                            cnt      <= CW'(LATENCY - 1);
                            state    <= ST_BUSY;
                        end
                    end
                end

                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Registered read; writes leave rdata untouched.
                        if (!op_write) begin
                            rdata <= mem[idx];
                        end
                        ack   <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Inputs still show the completed instruction here, so
                    // they are not sampled; the next request is taken in IDLE.
                    ack   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
                    err   <= 1'b0;
`endif
                    state <= ST_IDLE;
                end

                default: begin
                    ack   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Bench for dmem_responder. A transaction-level model (word array plus
// per-transaction timing arithmetic) supplies the expected outputs for every
// cycle; a single compare process checks them on the falling edge. Directed
// accesses with literal expectations pin the model, then randomised traffic
// (with input scrambling while the access is in flight) exercises the rest.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic [31:0] Alu_outM;
    logic [31:0] busbM;
    logic [31:0] rdataM;
    logic        stallM;
    logic        ackM;
    logic        errM;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemWriteM (MemWriteM),
        .MemtoRegM (MemtoRegM),
        .Alu_outM  (Alu_outM),
        .busbM     (busbM),
        .rdataM    (rdataM),
        .stallM    (stallM),
        .ackM      (ackM),
        .errM      (errM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int checks;
    int errors;
    int stall_total;

    // Model state
    logic [31:0] model_mem   [DEPTH];
    bit          model_valid [DEPTH];
    logic        exp_stall;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          exp_known;
    bit          chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallM", {31'b0, stallM}, {31'b0, exp_stall});
            chk("ackM",   {31'b0, ackM},   {31'b0, exp_ack});
            chk("errM",   {31'b0, errM},   {31'b0, exp_err});
            if (exp_known) chk("rdataM", rdataM, exp_rdata);
            if (stallM === 1'b1) stall_total++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        MemWriteM = 1'($urandom);
        MemtoRegM = 1'($urandom);
        Alu_outM  = $urandom;
        busbM     = $urandom;
    endtask

    // One pipeline instruction: drives the request in its first cycle and
    // sets per-cycle expectations from the transaction timing rules.
    task automatic access(input bit we, input bit re, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold_quiet);
        int idx;
        bit mis;
        int stall_start;
        idx = int'(addr[AW+1:2]);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (addr[1:0] != 2'b00);
`endif
        MemWriteM = we;
        MemtoRegM = re;
        Alu_outM  = addr;
        busbM     = wdata;
        exp_err   = 1'b0;
        if (!(we || re)) begin
            exp_stall = 1'b0;
            exp_ack   = 1'b0;
            next_cycle();
            return;
        end
        stall_start = stall_total;
        exp_stall = 1'b1;
        exp_ack   = 1'b0;
        if (mis) begin
            next_cycle();
        end else begin
            for (int k = 0; k <= LAT; k++) begin
                if (k > 0 && !hold_quiet) scramble();
                next_cycle();
            end
        end
        // DONE cycle
        if (!hold_quiet) scramble();
        exp_stall = 1'b0;
        exp_ack   = 1'b1;
        exp_err   = mis;
        if (mis) begin
            exp_rdata = 32'h0;
            exp_known = 1'b1;
        end else if (we) begin
            model_mem[idx]   = wdata;
            model_valid[idx] = 1'b1;
        end else begin
            exp_rdata = model_mem[idx];
            exp_known = model_valid[idx];
        end
        next_cycle();
        exp_ack = 1'b0;
        exp_err = 1'b0;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
        exp_stall = 1'b0;
        chk("stall_len", 32'(stall_total - stall_start), mis ? 32'd1 : 32'(LAT + 1));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        stall_total = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model_valid[i] = 1'b0;
            model_mem[i]   = '0;
        end
        rst_n     = 1'b0;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
        Alu_outM  = '0;
        busbM     = '0;
        exp_stall = 1'b0;
        exp_ack   = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        exp_known = 1'b1;
        chk_en    = 1'b1;

        // Reset held with no request: all outputs 0.
        next_cycle();
        next_cycle();
        chk("reset_rdata", rdataM, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) next_cycle();
        chk("idle_no_stall", 32'(stall_total), 32'd0);

        // Store then load at 0x40.
        begin
            int s0;
            s0 = stall_total;
            access(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1);
            chk("store_stall3", 32'(stall_total - s0), 32'd3);
        end
        access(1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
        chk("load_40", rdataM, 32'hDEADBEEF);

        // Wrap: 0x1000 aliases index 0.
        access(1'b1, 1'b0, 32'h1000, 32'h12345678, 1'b1);
        access(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        chk("wrap_load", rdataM, 32'h12345678);

        // Simultaneous request is a write; rdata keeps its value.
        access(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
        chk("both_keeps_rdata", rdataM, 32'h12345678);
        access(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
        chk("both_wrote", rdataM, 32'hA5A5A5A5);

        // Reset during BUSY discards the store and clears rdata.
        access(1'b1, 1'b0, 32'h20, 32'h11111111, 1'b1);
        MemWriteM = 1'b1;
        MemtoRegM = 1'b0;
        Alu_outM  = 32'h20;
        busbM     = 32'hFFFFFFFF;
        exp_stall = 1'b1;
        next_cycle();
        #2;
        rst_n     = 1'b0;
        MemWriteM = 1'b0;
        exp_stall = 1'b0;
        exp_rdata = 32'h0;
        exp_known = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        chk("reset_mid_rdata", rdataM, 32'h0);
        access(1'b0, 1'b1, 32'h20, 32'h0, 1'b1);
        chk("reset_mid_kept", rdataM, 32'h11111111);

        // Misaligned load from 0x42.
        access(1'b0, 1'b1, 32'h42, 32'h0, 1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign_trap", rdataM, 32'h0);
`else
        chk("misalign_word", rdataM, 32'hDEADBEEF);
`endif

        // Randomised traffic over a small index window so reads hit stores.
        for (int t = 0; t < 300; t++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            case (op)
                0:          access(1'b0, 1'b0, a, $urandom, 1'b0);
                1, 2, 3:    access(1'b1, 1'b0, a, $urandom, 1'b0);
                4:          access(1'b1, 1'b1, a, $urandom, 1'b0);
                default:    access(1'b0, 1'b1, a, $urandom, 1'b0);
            endcase
        end

        next_cycle();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
